mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-port memory between the CPU instruction-fetch port and the load/store data port.
// - Sits between the fetch/LSU logic and the unified 4KB memory.
// - Accepts one transaction at a time and forwards it to memory.
// - Returns the response to the requester that issued it.
// - Priority is data over fetch, with a bounded-starvation guarantee for fetch.
// - Gives up on a memory grant that never arrives (grant timeout).
// PARAMETERS
// - MAX_DATA_STREAK  4   consecutive data grants allowed while fetch waits (legal 1..15)
// - GNT_TIMEOUT      16  cycles in ISSUE without m_gnt before error abort (legal 2..255)
// PORTS
// - clk        in   1   clock, rising edge
// - reset      in   1   asynchronous, active-high
// - i_req      in   1   fetch request; held with i_addr stable until i_gnt
// - i_addr     in   32  fetch byte address (word aligned)
// - i_gnt      out  1   fetch request accepted (1-cycle pulse)
// - i_rvalid   out  1   fetch response valid (1-cycle pulse)
// - i_rdata    out  32  fetch data; 0 when i_rvalid=0 or on error
// - i_err      out  1   fetch aborted by timeout; qualifies i_rvalid
// - d_req      in   1   data request; d_* inputs held stable until d_gnt
// - d_we       in   1   1 = store, 0 = load
// - d_be       in   4   store byte enables
// - d_addr     in   32  data byte address
// - d_wdata    in   32  store data
// - d_gnt      out  1   data request accepted (1-cycle pulse)
// - d_rvalid   out  1   load data or store completion (1-cycle pulse)
// - d_rdata    out  32  load data; 0 for stores, on error, or when d_rvalid=0
// - d_err      out  1   data transaction aborted by timeout; qualifies d_rvalid
// - m_req      out  1   memory request, held until m_gnt or timeout
// - m_we       out  1   registered copy of winner's we (0 for fetch)
// - m_be       out  4   registered byte enables (4'hF for fetch)
// - m_addr     out  32  registered address
// - m_wdata    out  32  registered write data (0 for fetch)
// - m_gnt      in   1   memory accepted request this cycle
// - m_rvalid   in   1   memory response; exactly one per m_gnt, >=1 cycle after it
// - m_rdata    in   32  memory read data, valid with m_rvalid
// BEHAVIOUR
// - Reset:
//   - state = IDLE, owner = fetch.
//   - All outputs and the m_* registers are 0.
//   - streak and timeout counters are cleared.
//   - Reset mid-transaction abandons the transaction; no response is returned.
//   - Any m_rvalid that arrives after reset, outside WAIT, is ignored.
// - FSM states: IDLE, ISSUE, WAIT.
//   - IDLE:
//     - If any request is present, pick a winner.
//     - Assert its x_gnt combinationally in this same cycle.
//     - Latch its fields into m_* and record owner.
//     - Go to ISSUE.
//   - ISSUE:
//     - m_req = 1.
//     - If m_gnt: go to WAIT.
//     - Else if tcnt == GNT_TIMEOUT-1: drop m_req, pulse owner x_rvalid and x_err (rdata 0), go to IDLE.
//     - tcnt is cleared on entry to ISSUE and increments each ISSUE cycle.
//   - WAIT:
//     - m_req = 0. No timeout.
//     - On m_rvalid: owner x_rvalid = 1 in the same cycle (combinational).
//       - Fetch or load: x_rdata = m_rdata.
//       - Store: x_rdata = 0.
//     - Then go to IDLE.
// - Arbitration, evaluated in IDLE only:
//   - Only d_req: data wins. Only i_req: fetch wins.
//   - Both requesting: data wins unless streak == MAX_DATA_STREAK, in which case fetch wins.
//   - streak increments on a data grant made while i_req=1, saturating at MAX_DATA_STREAK.
//   - streak clears on any fetch grant.
//   - A data grant with i_req=0 leaves streak unchanged.
// - Throughput and latency:
//   - Minimum 3 cycles per transaction: IDLE, ISSUE with m_gnt, WAIT with m_rvalid.
//   - A request arriving in the same cycle as a completion is granted in the following IDLE cycle (one bubble).
// - Not-owner outputs stay 0.
//   - i_gnt and d_gnt are never both 1.
//   - i_rvalid and d_rvalid are never both 1.
// - Requests that are dropped before their grant are legal: they are simply not granted.
// - m_gnt outside ISSUE is ignored.
// TESTING
// - Fetch read: i_req, addr 0x40; m_gnt in ISSUE cycle 1, m_rvalid next cycle with rdata 0x00500093.
//   -> i_gnt at cycle 0, i_rvalid with i_rdata 0x00500093 at cycle 2, i_err=0.
// - Store: d_we=1, be 4'b0011, addr 0x104, wdata 0xDEAD_BEEF.
//   -> m_we=1, m_be=4'b0011, m_addr=0x104, m_wdata=0xDEADBEEF; d_rvalid pulse with d_rdata=0.
// - Contention: i_req and d_req held high continuously, MAX_DATA_STREAK=4.
//   -> grant order D,D,D,D,I,D,D,D,D,I; the two gnt signals are never both high.
// - Timeout: d_req granted, m_gnt held 0.
//   -> m_req high for exactly 16 cycles, then d_rvalid=1, d_err=1, d_rdata=0; a following i_req is served normally.
// - Async reset asserted in WAIT, then a stale m_rvalid after release.
//   -> all outputs 0 immediately; no x_rvalid from the stale response; next i_req is granted from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store ports.
// Data has priority; fetch is guaranteed a grant after MAX_DATA_STREAK data grants.
module mem_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int GNT_TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  // load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // memory port
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  // observability
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds x_req and its fields stable until the
  // one-cycle x_gnt pulse; exactly one x_rvalid pulse (possibly with x_err)
  // follows each grant. Memory side: m_req holds until m_gnt or timeout,
  // and exactly one m_rvalid follows each m_gnt.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
  localparam logic [7:0] TCNT_LAST  = 8'(GNT_TIMEOUT - 1);

  state_t      state;
  logic        owner_data;
  logic [3:0]  streak;
  logic [7:0]  tcnt;

  logic        pick_data;
  logic        pick_fetch;
  logic        in_idle;
  logic        timeout;
  logic        resp;
  logic        done;

  // Fetch overrides data only once data has won MAX_DATA_STREAK times in a row.
  always_comb begin
    pick_data  = d_req && !(i_req && (streak == STREAK_MAX));
    pick_fetch = i_req && !pick_data;
    in_idle    = (state == S_IDLE) && !reset;
    timeout    = (state == S_ISSUE) && !m_gnt && (tcnt == TCNT_LAST);
    resp       = (state == S_WAIT) && m_rvalid;
    done       = timeout || resp;
  end

  always_comb begin
    i_gnt     = in_idle && pick_fetch;
    d_gnt     = in_idle && pick_data;
    m_req     = (state == S_ISSUE);
    i_rvalid  = done && !owner_data;
    d_rvalid  = done && owner_data;
    i_err     = timeout && !owner_data;
    d_err     = timeout && owner_data;
    i_rdata   = (resp && !owner_data) ? m_rdata : 32'h0;
    d_rdata   = (resp && owner_data && !m_we) ? m_rdata : 32'h0;
    dbg_state = state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      owner_data <= 1'b0;
      streak     <= 4'd0;
      tcnt       <= 8'd0;
      m_we       <= 1'b0;
      m_be       <= 4'h0;
      m_addr     <= 32'h0;
      m_wdata    <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_data) begin
            owner_data <= 1'b1;
            m_we       <= d_we;
            m_be       <= d_be;
            m_addr     <= d_addr;
            m_wdata    <= d_wdata;
            tcnt       <= 8'd0;
            state      <= S_ISSUE;
            if (i_req && (streak != STREAK_MAX)) streak <= streak + 4'd1;
          end else if (pick_fetch) begin
            owner_data <= 1'b0;
            m_we       <= 1'b0;
            m_be       <= 4'hF;
            m_addr     <= i_addr;
            m_wdata    <= 32'h0;
            tcnt       <= 8'd0;
            streak     <= 4'd0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (m_gnt) begin
            state <= S_WAIT;
          end else if (tcnt == TCNT_LAST) begin
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (m_rvalid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) !(i_gnt && d_gnt));
  a_rvalid_onehot: assert property (@(posedge clk) disable iff (reset) !(i_rvalid && d_rvalid));
  a_gnt_only_idle: assert property (@(posedge clk) disable iff (reset)
    (i_gnt || d_gnt) |-> (state == S_IDLE));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model with a memory array and expected queue.
module tb_mem_port_arbiter;

  localparam int MAX_STREAK = 4;
  localparam int TIMEOUT    = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_gnt, m_rvalid;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.MAX_DATA_STREAK(MAX_STREAK), .GNT_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] all_outputs();
    return {dbg_state, i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
            m_req, m_we, m_be, m_addr, m_wdata};
  endfunction

  task automatic idle_inputs();
    i_req = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    m_gnt = 0; m_rvalid = 0; m_rdata = 0;
  endtask

  // directed fetch: grant at cycle 0, m_gnt in first ISSUE cycle, response next
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1; i_req = 1; i_addr = addr;
    @(negedge clk);
    check_eq({tag, "_gnt"}, {i_gnt, d_gnt}, 2'b10);
    @(posedge clk); #1; i_req = 0; m_gnt = 1;
    @(negedge clk);
    check_eq({tag, "_mreq"}, {m_req, m_we, m_be, m_addr, m_wdata}, {1'b1, 1'b0, 4'hF, addr, 32'h0});
    @(posedge clk); #1; m_gnt = 0; m_rvalid = 1; m_rdata = data;
    @(negedge clk);
    check_eq({tag, "_resp"}, {i_rvalid, i_rdata, i_err, d_rvalid}, {1'b1, data, 1'b0, 1'b0});
    @(posedge clk); #1; m_rvalid = 0; m_rdata = 0;
  endtask

  // ---------------- random engine: model and scoreboard ----------------
  logic [31:0] mem [0:1023];
  logic [32:0] exp_q[$];          // {owner_is_data, expected rdata}
  int          streak_m;
  bit          i_pend, d_pend, gen_on, chk_m_next, cur_data, mem_busy;
  int          i_age, d_age, rsp_wait, mreq_run, n_grants;
  logic [31:0] i_a, d_a, d_wd, rsp_data;
  logic [3:0]  d_b;
  logic        d_w;
  logic [68:0] exp_m;             // {we, be, addr, wdata}
  logic [9:0]  grant_seq;

  task automatic drive_mem(input int gnt_pct, input int lat_max);
    m_gnt = 0; m_rvalid = 0; m_rdata = $urandom;
    if (rsp_wait > 0) begin
      rsp_wait--;
      if (rsp_wait == 0) begin
        m_rvalid = 1; m_rdata = rsp_data; mem_busy = 0;
      end
    end
    if (m_req && !mem_busy) begin
      if ($urandom_range(0, 99) < gnt_pct || mreq_run >= 10) m_gnt = 1;
      mreq_run++;
    end else begin
      mreq_run = 0;
    end
  endtask

  task automatic drive_reqs(input bit always_req);
    if (gen_on && !i_pend && (always_req || $urandom_range(0, 2) == 0)) begin
      i_pend = 1; i_age = 0;
      i_a = $urandom & 32'hFFFF_FFFC;
    end
    if (gen_on && !d_pend && (always_req || $urandom_range(0, 2) == 0)) begin
      d_pend = 1; d_age = 0;
      d_a  = $urandom & 32'hFFFF_FFFC;
      d_w  = 1'($urandom_range(0, 1));
      d_b  = 4'($urandom_range(1, 15));
      d_wd = $urandom;
    end
    i_req = i_pend; i_addr = i_a;
    d_req = d_pend; d_addr = d_a; d_we = d_w; d_be = d_b; d_wdata = d_wd;
  endtask

  task automatic score(input int lat_max);
    logic [32:0] e;
    logic [31:0] rd;
    logic [9:0]  idx;
    bit          want_data;
    check_eq("gnt_onehot", i_gnt && d_gnt, 1'b0);
    if (chk_m_next) begin
      check_eq("m_fields", {m_req, m_we, m_be, m_addr, m_wdata}, {1'b1, exp_m});
      chk_m_next = 0;
    end
    if (i_gnt || d_gnt) begin
      want_data = d_pend && !(i_pend && streak_m >= MAX_STREAK);
      check_eq("winner", {i_gnt, d_gnt}, want_data ? 2'b01 : (i_pend ? 2'b10 : 2'b00));
      if (d_gnt) begin
        exp_m = {d_w, d_b, d_a, d_wd}; cur_data = 1;
        if (i_pend && streak_m < MAX_STREAK) streak_m++;
        d_pend = 0;
      end else begin
        exp_m = {1'b0, 4'hF, i_a, 32'h0}; cur_data = 0;
        streak_m = 0; i_pend = 0;
      end
      if (n_grants < 10) grant_seq = {grant_seq[8:0], cur_data};
      n_grants++;
      chk_m_next = 1;
    end
    if (m_req && m_gnt) begin
      idx = exp_m[43:34];
      rd  = mem[idx];
      if (cur_data && exp_m[68]) begin
        for (int b = 0; b < 4; b++)
          if (exp_m[64 + b]) mem[idx][8*b +: 8] = exp_m[8*b +: 8];
        exp_q.push_back({1'b1, 32'h0});
        rsp_data = $urandom;
      end else begin
        exp_q.push_back({cur_data, rd});
        rsp_data = rd;
      end
      rsp_wait = $urandom_range(1, lat_max);
      mem_busy = 1;
    end
    if (i_rvalid || d_rvalid) begin
      if (exp_q.size() == 0) begin
        check_eq("resp_unexpected", {i_rvalid, d_rvalid}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check_eq("resp", {d_rvalid, i_rvalid, i_err, d_err, i_rdata, d_rdata},
                 {e[32], !e[32], 2'b00, e[32] ? 32'h0 : e[31:0], e[32] ? e[31:0] : 32'h0});
      end
    end else begin
      check_eq("idle_rdata", {i_rdata, d_rdata, i_err, d_err}, 66'h0);
    end
    if (i_pend) i_age++;
    if (d_pend) d_age++;
    if (i_age > 120) begin check_eq("fetch_starved", i_age, 0); i_age = 0; end
    if (d_age > 120) begin check_eq("data_starved", d_age, 0); d_age = 0; end
  endtask

  task automatic run_engine(input int n, input bit contention);
    bit drained = 0;
    gen_on = 1; i_pend = 0; d_pend = 0; chk_m_next = 0; mem_busy = 0;
    rsp_wait = 0; mreq_run = 0; n_grants = 0; grant_seq = 0; streak_m = 0;
    exp_q.delete();
    for (int c = 0; c < n + 400; c++) begin
      if (c >= n || (contention && n_grants >= 10)) gen_on = 0;
      @(posedge clk); #1;
      drive_mem(contention ? 100 : 60, contention ? 1 : 3);
      drive_reqs(contention);
      @(negedge clk);
      score(contention ? 1 : 3);
      if (!gen_on && !i_pend && !d_pend && exp_q.size() == 0 && !mem_busy &&
          !chk_m_next && !m_req) begin
        drained = 1;
        break;
      end
    end
    check_eq("drain", drained, 1'b1);
    @(posedge clk); #1; idle_inputs();
  endtask

  // ---------------- main sequence ----------------
  int          cnt;
  bit          got;
  logic [9:0]  exp_seq;

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = $urandom;
    idle_inputs();
    reset = 1;
    #12;
    check_eq("reset_outputs", all_outputs(), 144'h0);
    @(negedge clk); reset = 0;

    // fetch read
    do_fetch("fetch", 32'h40, 32'h0050_0093);

    // store with partial byte enables; memory returns garbage that must not leak
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h104; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("store_gnt", {i_gnt, d_gnt}, 2'b01);
    @(posedge clk); #1; d_req = 0; m_gnt = 1;
    @(negedge clk);
    check_eq("store_mreq", {m_req, m_we, m_be, m_addr, m_wdata},
             {1'b1, 1'b1, 4'b0011, 32'h104, 32'hDEAD_BEEF});
    @(posedge clk); #1; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h1234_5678;
    @(negedge clk);
    check_eq("store_resp", {d_rvalid, d_rdata, d_err, i_rvalid}, {1'b1, 32'h0, 1'b0, 1'b0});
    @(posedge clk); #1; m_rvalid = 0; m_rdata = 0;

    // grant timeout on a load
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200; m_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_eq("to_gnt", d_gnt, 1'b1);
    cnt = 0; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1; d_req = 0;
      @(negedge clk);
      if (m_req) cnt++;
      if (d_rvalid) begin
        got = 1;
        check_eq("to_resp", {d_rvalid, d_err, d_rdata, i_rvalid}, {1'b1, 1'b1, 32'h0, 1'b0});
      end
    end
    check_eq("to_seen", got, 1'b1);
    check_eq("to_mreq_cycles", cnt, TIMEOUT);
    @(posedge clk); #1; m_rdata = 0;
    @(negedge clk);
    check_eq("to_mreq_drop", {m_req, d_rvalid, d_err}, 3'b000);
    do_fetch("after_to", 32'h8, 32'hCAFE_0001);

    // async reset while waiting for the memory response, then a stale response
    @(posedge clk); #1; i_req = 1; i_addr = 32'h80;
    @(negedge clk);
    check_eq("rst_gnt", i_gnt, 1'b1);
    @(posedge clk); #1; i_req = 0; m_gnt = 1;
    @(posedge clk); #1; m_gnt = 0;
    #2 reset = 1;
    #1 check_eq("rst_wait_outputs", all_outputs(), 144'h0);
    @(negedge clk); reset = 0;
    @(posedge clk); #1; m_rvalid = 1; m_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    check_eq("stale_rvalid", {i_rvalid, d_rvalid, i_rdata, d_rdata}, 66'h0);
    @(posedge clk); #1; m_rvalid = 0; m_rdata = 0;
    do_fetch("after_rst", 32'h44, 32'h7777_1111);

    // contention: both ports always requesting
    run_engine(200, 1'b1);
    exp_seq = 10'b1111011110;
    check_eq("contention_order", grant_seq, exp_seq);
    check_eq("contention_count", n_grants >= 10, 1'b1);

    // randomized traffic
    run_engine(600, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
